sa_feed_sequencer: RTL and testbench

- Upstream feeder for the systolic-array controller and PE grid.
- On a start pulse, reads N weight rows from the local operand SRAM and presents them unskewed with w_ps=1.
- Then streams a_len activation rows with diagonal skew (lane i delayed i cycles) and w_ps=0, flushes the skew with zeros, and pulses done.
- Produces the w_ps and row data consumed by the array controller.

---
 rtl/sa_feed_sequencer.sv | 140 ++++++++++++++
 tb/tb_sa_feed_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sa_feed_sequencer.sv
// Systolic-array feed sequencer: loads N weight rows, then streams
// skewed activation rows, flushes the skew and pulses done.
module sa_feed_sequencer #(
   parameter int N      = 4,
   parameter int DW     = 8,
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] w_base,
   input  logic [ADDR_W-1:0] a_base,
   input  logic [LEN_W-1:0]  a_len,
   output logic              busy,
   output logic              done,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [N*DW-1:0]   mem_rdata,
   output logic              w_ps,
   output logic              row_valid,
   output logic [N*DW-1:0]   row_data
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      STREAM_A,
      DRAIN,
      DONE
   } state_t;

   localparam logic [LEN_W-1:0] LAST = LEN_W'(N - 1);

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] a_base_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt;
   logic              w_vld;
   logic [N-1:0]      a_sh;
   logic [N*DW-1:0]   a_in;
   logic [N*DW-1:0]   skew;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         addr     <= '0;
         a_base_q <= '0;
         len_q    <= '0;
         cnt      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state    <= LOAD_W;
                  addr     <= w_base;
                  a_base_q <= a_base;
                  len_q    <= a_len;
                  cnt      <= '0;
               end
            end
            LOAD_W: begin
               addr <= addr + 1'b1;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  cnt <= '0;
                  if (len_q == '0) begin
                     // one slot so the last weight row lands before done
                     state <= DRAIN;
                     cnt   <= LAST;
                  end else begin
                     state <= STREAM_A;
                     addr  <= a_base_q;
                  end
               end
            end
            STREAM_A: begin
               addr <= addr + 1'b1;
               cnt  <= cnt + 1'b1;
               if (cnt == len_q - LEN_W'(1)) begin
                  state <= DRAIN;
                  cnt   <= '0;
               end
            end
            DRAIN: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= DONE;
                  cnt   <= '0;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy     = (state == LOAD_W) || (state == STREAM_A)
                     || (state == DRAIN);
   assign done     = (state == DONE);
   assign mem_re   = (state == LOAD_W) || (state == STREAM_A);
   assign mem_addr = mem_re ? addr : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_vld <= 1'b0;
         a_sh  <= '0;
      end else begin
         w_vld <= (state == LOAD_W);
         a_sh  <= {a_sh[N-2:0], (state == STREAM_A)};
      end
   end

   // only A-phase read data may enter the skew chains
   assign a_in = a_sh[0] ? mem_rdata : '0;

   for (genvar i = 0; i < N; i++) begin : g_lane
      if (i == 0) begin : g_direct
         assign skew[DW-1:0] = a_in[DW-1:0];
      end else begin : g_chain
         logic [DW-1:0] ch [i];
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int k = 0; k < i; k++) ch[k] <= '0;
            end else begin
               ch[0] <= a_in[i*DW +: DW];
               for (int k = 1; k < i; k++) ch[k] <= ch[k-1];
            end
         end
         assign skew[i*DW +: DW] = ch[i-1];
      end
   end

   assign w_ps      = w_vld;
   assign row_valid = w_vld || (|a_sh);
   assign row_data  = w_vld ? mem_rdata
                    : (|a_sh) ? skew : '0;

endmodule

// File: tb/tb_sa_feed_sequencer.sv
// Self-checking bench for sa_feed_sequencer: random SRAM contents,
// per-cycle expectations computed from the tile timing rules.
module tb_sa_feed_sequencer;

   localparam int N = 4;
   localparam int DW = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  w_base = '0;
   logic [9:0]  a_base = '0;
   logic [9:0]  a_len = '0;
   logic        busy, done, mem_re, w_ps, row_valid;
   logic [9:0]  mem_addr;
   logic [31:0] mem_rdata;
   logic [31:0] row_data;

   logic [31:0] mem [1024];

   int checks = 0;
   int errors = 0;

   sa_feed_sequencer #(.N(N), .DW(DW), .ADDR_W(10), .LEN_W(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .w_base    (w_base),
      .a_base    (a_base),
      .a_len     (a_len),
      .busy      (busy),
      .done      (done),
      .mem_re    (mem_re),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .w_ps      (w_ps),
      .row_valid (row_valid),
      .row_data  (row_data)
   );

   always #5 clk = ~clk;

   // SRAM: 1-cycle read latency, garbage on the bus when not reading
   always @(posedge clk)
      mem_rdata <= mem_re ? mem[mem_addr] : $urandom;

   task automatic chk(input string tag, input int cyc,
                      input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc %0d observed %h expected %h",
                tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 0, 32'(busy), 0);
      chk({tag, "_done"}, 0, 32'(done), 0);
      chk({tag, "_re"}, 0, 32'(mem_re), 0);
      chk({tag, "_addr"}, 0, 32'(mem_addr), 0);
      chk({tag, "_wps"}, 0, 32'(w_ps), 0);
      chk({tag, "_valid"}, 0, 32'(row_valid), 0);
      chk({tag, "_row"}, 0, row_data, 0);
   endtask

   task automatic run_tile(input logic [9:0] wb, input logic [9:0] ab,
                           input logic [9:0] ln, input bit hold);
      int total, l;
      logic        e_re, e_wps, e_av;
      logic [9:0]  e_addr;
      logic [31:0] e_row, r;
      l = int'(ln);
      @(negedge clk);
      start  = 1'b1;
      w_base = wb;
      a_base = ab;
      a_len  = ln;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      total = (l == 0) ? N + 2 : 2 * N + l + 1;
      for (int c = 1; c <= total + 1; c++) begin
         @(negedge clk);
         e_re   = (c >= 1) && (c <= N + l);
         e_addr = !e_re ? 10'd0
                : (c <= N) ? 10'(int'(wb) + c - 1)
                : 10'(int'(ab) + c - N - 1);
         e_wps  = (c >= 2) && (c <= N + 1);
         e_av   = (l > 0) && (c >= N + 2) && (c <= 2 * N + l);
         e_row  = '0;
         if (e_wps) e_row = mem[10'(int'(wb) + c - 2)];
         else if (e_av) begin
            for (int i = 0; i < N; i++) begin
               int j;
               j = c - N - 2 - i;
               if (j >= 0 && j < l) begin
                  r = mem[10'(int'(ab) + j)];
                  e_row[i*DW +: DW] = r[i*DW +: DW];
               end
            end
         end
         chk("busy", c, 32'(busy), 32'(c < total));
         chk("done", c, 32'(done), 32'(c == total));
         chk("mem_re", c, 32'(mem_re), 32'(e_re));
         chk("mem_addr", c, 32'(mem_addr), 32'(e_addr));
         chk("w_ps", c, 32'(w_ps), 32'(e_wps));
         chk("row_valid", c, 32'(row_valid), 32'(e_wps || e_av));
         chk("row_data", c, row_data, e_row);
         if (hold && c <= total) begin
            start  = 1'b1;
            w_base = 10'($urandom);
            a_base = 10'($urandom);
            a_len  = 10'($urandom);
         end
         if (c == total + 1) start = 1'b0;
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      for (int k = 0; k < N; k++) mem[16 + k] = {4{8'(k)}};

      #12;
      chk_idle("reset");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_idle("post_reset");

      run_tile(10'h010, 10'h020, 10'd3, 1'b0);
      run_tile(10'($urandom), 10'h3FE, 10'd4, 1'b0);
      run_tile(10'h3FD, 10'($urandom), 10'd0, 1'b0);
      run_tile(10'($urandom), 10'($urandom), 10'd5, 1'b1);
      for (int t = 0; t < 5; t++)
         run_tile(10'($urandom), 10'($urandom),
                  10'($urandom_range(0, 14)), 1'b0);
      run_tile(10'($urandom), 10'($urandom), 10'd1, 1'b0);

      // abandon a tile mid-stream
      @(negedge clk);
      start  = 1'b1;
      w_base = 10'($urandom);
      a_base = 10'($urandom);
      a_len  = 10'd10;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (N + 3) @(negedge clk);
      chk("mid_busy", 0, 32'(busy), 1);
      rst = 1'b0;
      #1;
      chk_idle("async_rst");
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("no_done", c, 32'(done), 0);
         chk("no_busy", c, 32'(busy), 0);
      end
      run_tile(10'($urandom), 10'($urandom), 10'd6, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
